// File: rtl/ex_operand_stage.sv
// ID/EX pipeline register with load-use hazard detection and EX operand forwarding.
// Latency: one cycle from ID fields to ex_* outputs; forward muxes and stall are combinational.
// Backpressure: ex_hold freezes EX and raises stall; load-use raises stall and bubbles EX.
module ex_operand_stage #(
  parameter int XLEN = 32,
  parameter int RIDX = 5
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            id_valid,
  input  logic [RIDX-1:0] id_rs1,
  input  logic [RIDX-1:0] id_rs2,
  input  logic [RIDX-1:0] id_rd,
  input  logic            id_rs2_used,
  input  logic [XLEN-1:0] id_rs1_data,
  input  logic [XLEN-1:0] id_rs2_data,
  input  logic [XLEN-1:0] id_imm,
  input  logic            id_alu_src,
  input  logic [3:0]      id_alu_control,
  input  logic            id_reg_write,
  input  logic            id_mem_read,
  input  logic            id_mem_write,
  input  logic            exmem_reg_write,
  input  logic [RIDX-1:0] exmem_rd,
  input  logic [XLEN-1:0] exmem_result,
  input  logic            memwb_reg_write,
  input  logic [RIDX-1:0] memwb_rd,
  input  logic [XLEN-1:0] memwb_result,
  input  logic            flush,
  input  logic            ex_hold,
  output logic            stall,
  output logic            ex_valid,
  output logic [XLEN-1:0] ex_a,
  output logic [XLEN-1:0] ex_b,
  output logic [3:0]      ex_alu_control,
  output logic [XLEN-1:0] ex_store_data,
  output logic [RIDX-1:0] ex_rd,
  output logic            ex_reg_write,
  output logic            ex_mem_read,
  output logic            ex_mem_write
);

  // Registered ID/EX fields
  logic            valid_q,     valid_d;
  logic [RIDX-1:0] rs1_q,       rs1_d;
  logic [RIDX-1:0] rs2_q,       rs2_d;
  logic [RIDX-1:0] rd_q,        rd_d;
  logic [XLEN-1:0] rs1_data_q,  rs1_data_d;
  logic [XLEN-1:0] rs2_data_q,  rs2_data_d;
  logic [XLEN-1:0] imm_q,       imm_d;
  logic            alu_src_q,   alu_src_d;
  logic [3:0]      alu_ctl_q,   alu_ctl_d;
  logic            reg_write_q, reg_write_d;
  logic            mem_read_q,  mem_read_d;
  logic            mem_write_q, mem_write_d;

  logic            lu;
  logic [XLEN-1:0] fwd_rs1;
  logic [XLEN-1:0] fwd_rs2;

  // Bypass select: EX/MEM beats MEM/WB, and x0 is never forwarded.
  function automatic logic [XLEN-1:0] fwd_sel(
    input logic [RIDX-1:0] idx,
    input logic [XLEN-1:0] rf_data,
    input logic            em_we,
    input logic [RIDX-1:0] em_rd,
    input logic [XLEN-1:0] em_res,
    input logic            mw_we,
    input logic [RIDX-1:0] mw_rd,
    input logic [XLEN-1:0] mw_res
  );
    logic [XLEN-1:0] r;
    r = rf_data;
    if (em_we && (em_rd != '0) && (em_rd == idx)) begin
      r = em_res;
    end else if (mw_we && (mw_rd != '0) && (mw_rd == idx)) begin
      r = mw_res;
    end
    return r;
  endfunction

  // Load-use hazard: a load in EX whose destination is read by the instruction in ID.
  always_comb begin
    lu = valid_q & mem_read_q & (rd_q != '0) & id_valid &
         ((rd_q == id_rs1) | (id_rs2_used & (rd_q == id_rs2)));
  end

  assign stall = lu | ex_hold;

  // Next-state: hold (unless flushed), bubble, or capture ID.
  always_comb begin
    valid_d     = valid_q;
    rs1_d       = rs1_q;
    rs2_d       = rs2_q;
    rd_d        = rd_q;
    rs1_data_d  = rs1_data_q;
    rs2_data_d  = rs2_data_q;
    imm_d       = imm_q;
    alu_src_d   = alu_src_q;
    alu_ctl_d   = alu_ctl_q;
    reg_write_d = reg_write_q;
    mem_read_d  = mem_read_q;
    mem_write_d = mem_write_q;
    if (ex_hold && !flush) begin
      // keep everything as is
    end else if (flush || lu || !id_valid) begin
      // a bubble is an all-zero entry so every output reads as idle
      valid_d     = 1'b0;
      rs1_d       = '0;
      rs2_d       = '0;
      rd_d        = '0;
      rs1_data_d  = '0;
      rs2_data_d  = '0;
      imm_d       = '0;
      alu_src_d   = 1'b0;
      alu_ctl_d   = 4'b0000;
      reg_write_d = 1'b0;
      mem_read_d  = 1'b0;
      mem_write_d = 1'b0;
    end else begin
      valid_d     = 1'b1;
      rs1_d       = id_rs1;
      rs2_d       = id_rs2;
      rd_d        = id_rd;
      rs1_data_d  = id_rs1_data;
      rs2_data_d  = id_rs2_data;
      imm_d       = id_imm;
      alu_src_d   = id_alu_src;
      alu_ctl_d   = id_alu_control;
      reg_write_d = id_reg_write;
      mem_read_d  = id_mem_read;
      mem_write_d = id_mem_write;
    end
  end

  // ID/EX register with asynchronous clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q     <= 1'b0;
      rs1_q       <= '0;
      rs2_q       <= '0;
      rd_q        <= '0;
      rs1_data_q  <= '0;
      rs2_data_q  <= '0;
      imm_q       <= '0;
      alu_src_q   <= 1'b0;
      alu_ctl_q   <= 4'b0000;
      reg_write_q <= 1'b0;
      mem_read_q  <= 1'b0;
      mem_write_q <= 1'b0;
    end else begin
      valid_q     <= valid_d;
      rs1_q       <= rs1_d;
      rs2_q       <= rs2_d;
      rd_q        <= rd_d;
      rs1_data_q  <= rs1_data_d;
      rs2_data_q  <= rs2_data_d;
      imm_q       <= imm_d;
      alu_src_q   <= alu_src_d;
      alu_ctl_q   <= alu_ctl_d;
      reg_write_q <= reg_write_d;
      mem_read_q  <= mem_read_d;
      mem_write_q <= mem_write_d;
    end
  end

  // Forward muxes track the source buses every cycle, including while held.
  always_comb begin
    fwd_rs1 = fwd_sel(rs1_q, rs1_data_q, exmem_reg_write, exmem_rd, exmem_result,
                      memwb_reg_write, memwb_rd, memwb_result);
    fwd_rs2 = fwd_sel(rs2_q, rs2_data_q, exmem_reg_write, exmem_rd, exmem_result,
                      memwb_reg_write, memwb_rd, memwb_result);
  end

  // Output drive; control bits are qualified by valid.
  always_comb begin
    ex_valid       = valid_q;
    ex_a           = fwd_rs1;
    ex_b           = alu_src_q ? imm_q : fwd_rs2;
    ex_store_data  = fwd_rs2;
    ex_alu_control = alu_ctl_q;
    ex_rd          = valid_q ? rd_q : '0;
    ex_reg_write   = valid_q & reg_write_q;
    ex_mem_read    = valid_q & mem_read_q;
    ex_mem_write   = valid_q & mem_write_q;
  end

endmodule

// File: tb/tb_ex_operand_stage.sv
// Bench for ex_operand_stage: directed pipeline scenarios then randomized traffic
// against an instruction-level model of the EX slot.
module tb_ex_operand_stage;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        id_valid = 0;
  logic [4:0]  id_rs1 = 0, id_rs2 = 0, id_rd = 0;
  logic        id_rs2_used = 0;
  logic [31:0] id_rs1_data = 0, id_rs2_data = 0, id_imm = 0;
  logic        id_alu_src = 0;
  logic [3:0]  id_alu_control = 0;
  logic        id_reg_write = 0, id_mem_read = 0, id_mem_write = 0;
  logic        exmem_reg_write = 0;
  logic [4:0]  exmem_rd = 0;
  logic [31:0] exmem_result = 0;
  logic        memwb_reg_write = 0;
  logic [4:0]  memwb_rd = 0;
  logic [31:0] memwb_result = 0;
  logic        flush = 0, ex_hold = 0;
  logic        stall, ex_valid;
  logic [31:0] ex_a, ex_b, ex_store_data;
  logic [3:0]  ex_alu_control;
  logic [4:0]  ex_rd;
  logic        ex_reg_write, ex_mem_read, ex_mem_write;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  ex_operand_stage #(.XLEN(32), .RIDX(5)) dut (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_rd(id_rd), .id_rs2_used(id_rs2_used), .id_rs1_data(id_rs1_data),
    .id_rs2_data(id_rs2_data), .id_imm(id_imm), .id_alu_src(id_alu_src),
    .id_alu_control(id_alu_control), .id_reg_write(id_reg_write),
    .id_mem_read(id_mem_read), .id_mem_write(id_mem_write),
    .exmem_reg_write(exmem_reg_write), .exmem_rd(exmem_rd), .exmem_result(exmem_result),
    .memwb_reg_write(memwb_reg_write), .memwb_rd(memwb_rd), .memwb_result(memwb_result),
    .flush(flush), .ex_hold(ex_hold), .stall(stall), .ex_valid(ex_valid),
    .ex_a(ex_a), .ex_b(ex_b), .ex_alu_control(ex_alu_control),
    .ex_store_data(ex_store_data), .ex_rd(ex_rd), .ex_reg_write(ex_reg_write),
    .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write)
  );

  // The instruction the model believes occupies EX (all zero means empty slot).
  typedef struct packed {
    logic        v;
    logic [4:0]  rs1, rs2, rd;
    logic [31:0] d1, d2, imm;
    logic        src;
    logic [3:0]  ctl;
    logic        rw, mr, mw;
  } instr_t;

  instr_t m = '0;

  // Architectural value of a source register as EX should see it.
  function automatic logic [31:0] operand(input logic [4:0] r, input logic [31:0] rf);
    if (r == 0) return rf;
    if (exmem_reg_write && exmem_rd == r) return exmem_result;
    if (memwb_reg_write && memwb_rd == r) return memwb_result;
    return rf;
  endfunction

  function automatic logic load_use();
    if (!(m.v && m.mr && m.rd != 0 && id_valid)) return 1'b0;
    return (m.rd == id_rs1) || (id_rs2_used && m.rd == id_rs2);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".stall"}, 32'(stall), 32'(load_use() || ex_hold));
    chk({tag, ".valid"}, 32'(ex_valid), 32'(m.v));
    chk({tag, ".a"}, ex_a, operand(m.rs1, m.d1));
    chk({tag, ".b"}, ex_b, m.src ? m.imm : operand(m.rs2, m.d2));
    chk({tag, ".sd"}, ex_store_data, operand(m.rs2, m.d2));
    chk({tag, ".ctl"}, 32'(ex_alu_control), 32'(m.ctl));
    chk({tag, ".rd"}, 32'(ex_rd), m.v ? 32'(m.rd) : 32'd0);
    chk({tag, ".rw"}, 32'(ex_reg_write), 32'(m.v && m.rw));
    chk({tag, ".mr"}, 32'(ex_mem_read), 32'(m.v && m.mr));
    chk({tag, ".mw"}, 32'(ex_mem_write), 32'(m.v && m.mw));
  endtask

  // Advance one clock; model decides what enters EX from the pre-edge inputs.
  task automatic tick();
    instr_t nxt;
    if (ex_hold && !flush) nxt = m;
    else if (flush || load_use() || !id_valid) nxt = '0;
    else nxt = '{1'b1, id_rs1, id_rs2, id_rd, id_rs1_data, id_rs2_data, id_imm,
                 id_alu_src, id_alu_control, id_reg_write, id_mem_read, id_mem_write};
    @(posedge clk);
    m = nxt;
    #1;
  endtask

  task automatic set_id(input logic v, input logic [4:0] rs1, input logic [4:0] rs2,
                        input logic [4:0] rd, input logic used, input logic [31:0] d1,
                        input logic [31:0] d2, input logic [31:0] imm, input logic src,
                        input logic [3:0] ctl, input logic rw, input logic mr,
                        input logic mw);
    id_valid = v; id_rs1 = rs1; id_rs2 = rs2; id_rd = rd; id_rs2_used = used;
    id_rs1_data = d1; id_rs2_data = d2; id_imm = imm; id_alu_src = src;
    id_alu_control = ctl; id_reg_write = rw; id_mem_read = mr; id_mem_write = mw;
  endtask

  initial begin
    // Reset state
    #12;
    check_all("rst");
    chk("rst_a", ex_a, 32'd0);
    rst = 1'b0;
    #1;
    check_all("rel");
    tick();
    check_all("idle");
    chk("idle_valid", 32'(ex_valid), 32'd0);
    chk("idle_stall", 32'(stall), 32'd0);

    // ADD x3,x1,x2 with no forwarding
    set_id(1, 5'd1, 5'd2, 5'd3, 1, 32'd5, 32'd7, 32'd0, 0, 4'b0010, 1, 0, 0);
    tick();
    set_id(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    #1;
    check_all("add");
    chk("add_a", ex_a, 32'd5);
    chk("add_b", ex_b, 32'd7);
    chk("add_ctl", 32'(ex_alu_control), 32'b0010);
    chk("add_rd", 32'(ex_rd), 32'd3);
    chk("add_rw", 32'(ex_reg_write), 32'd1);

    // Forwarding priority on rs1=3
    set_id(1, 5'd3, 5'd2, 5'd7, 1, 32'h99, 32'h1, 32'd0, 0, 4'b0010, 1, 0, 0);
    tick();
    exmem_reg_write = 1; exmem_rd = 5'd3; exmem_result = 32'h10;
    memwb_reg_write = 1; memwb_rd = 5'd3; memwb_result = 32'h20;
    #1;
    check_all("fwd_em");
    chk("fwd_em_a", ex_a, 32'h10);
    exmem_reg_write = 0;
    #1;
    check_all("fwd_mw");
    chk("fwd_mw_a", ex_a, 32'h20);

    // x0 is never forwarded
    set_id(1, 5'd0, 5'd2, 5'd7, 1, 32'h55, 32'h1, 32'd0, 0, 4'b0000, 1, 0, 0);
    tick();
    exmem_reg_write = 1; exmem_rd = 5'd0; memwb_rd = 5'd0;
    #1;
    check_all("x0");
    chk("x0_a", ex_a, 32'h55);
    exmem_reg_write = 0; memwb_reg_write = 0;

    // Load-use: LW x5 then ADD x6,x5,x1
    set_id(1, 5'd1, 5'd0, 5'd5, 0, 32'h100, 32'd0, 32'd4, 1, 4'b0010, 1, 1, 0);
    tick();
    set_id(1, 5'd5, 5'd1, 5'd6, 1, 32'hDEAD, 32'h3, 32'd0, 0, 4'b0010, 1, 0, 0);
    #1;
    check_all("lu");
    chk("lu_stall", 32'(stall), 32'd1);
    tick();
    check_all("lu_bub");
    chk("lu_bub_valid", 32'(ex_valid), 32'd0);
    chk("lu_bub_stall", 32'(stall), 32'd0);
    tick();
    set_id(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    memwb_reg_write = 1; memwb_rd = 5'd5; memwb_result = 32'hAB;
    #1;
    check_all("lu_fwd");
    chk("lu_fwd_a", ex_a, 32'hAB);
    memwb_reg_write = 0;

    // LW x5 then ADDI x6,x4,1 with rs2 field = 5 but unused
    set_id(1, 5'd1, 5'd0, 5'd5, 0, 32'h100, 32'd0, 32'd4, 1, 4'b0010, 1, 1, 0);
    tick();
    set_id(1, 5'd4, 5'd5, 5'd6, 0, 32'h9, 32'h0, 32'd1, 1, 4'b0010, 1, 0, 0);
    #1;
    check_all("addi");
    chk("addi_stall", 32'(stall), 32'd0);
    tick();
    check_all("addi_ex");
    chk("addi_rd", 32'(ex_rd), 32'd6);
    chk("addi_b", ex_b, 32'd1);

    // Hold for three cycles with ID changing underneath
    ex_hold = 1;
    set_id(1, 5'd9, 5'd10, 5'd11, 1, 32'h1234, 32'h5678, 32'd0, 0, 4'b0110, 1, 0, 1);
    for (int i = 0; i < 3; i++) begin
      #1;
      check_all("hold");
      chk("hold_rd", 32'(ex_rd), 32'd6);
      chk("hold_stall", 32'(stall), 32'd1);
      tick();
    end
    flush = 1;
    #1;
    check_all("hflush_pre");
    tick();
    flush = 0;
    check_all("hflush");
    chk("hflush_valid", 32'(ex_valid), 32'd0);

    // Asynchronous reset in the middle of a hold
    ex_hold = 0;
    set_id(1, 5'd2, 5'd3, 5'd4, 1, 32'h77, 32'h88, 32'd0, 0, 4'b0001, 1, 0, 0);
    tick();
    ex_hold = 1;
    #1;
    check_all("pre_arst");
    rst = 1;
    #2;
    m = '0;
    check_all("arst");
    chk("arst_a", ex_a, 32'd0);
    chk("arst_valid", 32'(ex_valid), 32'd0);
    rst = 0;
    ex_hold = 0;
    #1;

    // Randomized traffic with small register indices to provoke hazards
    for (int n = 0; n < 600; n++) begin
      set_id($urandom_range(0, 3) != 0, 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
             5'($urandom_range(0, 7)), 1'($urandom), $urandom, $urandom, $urandom,
             1'($urandom), 4'($urandom), 1'($urandom), $urandom_range(0, 2) == 0,
             1'($urandom));
      exmem_reg_write = 1'($urandom); exmem_rd = 5'($urandom_range(0, 7));
      exmem_result = $urandom;
      memwb_reg_write = 1'($urandom); memwb_rd = 5'($urandom_range(0, 7));
      memwb_result = $urandom;
      ex_hold = $urandom_range(0, 4) == 0;
      flush = $urandom_range(0, 7) == 0;
      #1;
      check_all("rnd");
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/ex_operand_stage.md
# ex_operand_stage

ID/EX pipeline register with load-use hazard detection and operand forwarding for the 5-stage RV32I core. It captures decoded fields from ID each cycle and presents the ALU's `A`, `B` and `ALUControl` in EX, with EX/MEM and MEM/WB results forwarded in. It asserts `stall` back to IF/ID on load-use hazards or a downstream hold, inserting bubbles into EX as needed.

## Interface
- `XLEN`, default 32: datapath width.
- `RIDX`, default 5: register index width.

- `clk` in 1: single clock; all state updates on rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `id_valid` in 1: ID holds a real instruction.
- `id_rs1`, `id_rs2`, `id_rd` in RIDX: register indices.
- `id_rs2_used` in 1: instruction reads rs2 (R-type, store, branch).
- `id_rs1_data`, `id_rs2_data` in XLEN: register-file read data.
- `id_imm` in XLEN: sign-extended immediate.
- `id_alu_src` in 1: 1 selects `id_imm` as ALU B.
- `id_alu_control` in 4: ALU op code (0000 AND, 0001 OR, 0010 ADD, 0110 SUB).
- `id_reg_write`, `id_mem_read`, `id_mem_write` in 1: control bits.
- `exmem_reg_write` in 1, `exmem_rd` in RIDX, `exmem_result` in XLEN: EX/MEM forward source.
- `memwb_reg_write` in 1, `memwb_rd` in RIDX, `memwb_result` in XLEN: MEM/WB forward source.
- `flush` in 1: kill the instruction entering EX (taken branch/jump).
- `ex_hold` in 1: downstream cannot accept; freeze EX.
- `stall` out 1: hold PC and IF/ID this cycle.
- `ex_valid` out 1: EX holds a real instruction.
- `ex_a`, `ex_b` out XLEN: ALU operands.
- `ex_alu_control` out 4: registered ALU op.
- `ex_store_data` out XLEN: forwarded rs2 for stores.
- `ex_rd` out RIDX; `ex_reg_write`, `ex_mem_read`, `ex_mem_write` out 1: registered control, gated by `ex_valid`.

## Operation
- Registered ID/EX fields: valid, rs1, rs2, rd, rs1_data, rs2_data, imm, alu_src, alu_control, reg_write, mem_read, mem_write.
- Load-use hazard `lu`: `ex_valid & ex_mem_read & ex_rd!=0 & id_valid & (ex_rd==id_rs1 | (id_rs2_used & ex_rd==id_rs2))`.
- `stall = lu | ex_hold` (combinational).
- Edge update priority:
  1. `rst`
  2. `ex_hold & !flush`: hold all fields.
  3. `flush | lu | !id_valid`: bubble; all registered fields cleared to 0.
  4. Otherwise: load ID fields.
- Forwarding per source `s` (rs1, rs2), evaluated on the registered index:
  - `exmem_reg_write & exmem_rd!=0 & exmem_rd==s` selects `exmem_result`.
  - Else `memwb_reg_write & memwb_rd!=0 & memwb_rd==s` selects `memwb_result`.
  - Else the registered register-file data.
  - EX/MEM has priority over MEM/WB. x0 is never forwarded.
- Output assignments:
  - `ex_a` = fwd(rs1).
  - `ex_b` = alu_src ? imm : fwd(rs2).
  - `ex_store_data` = fwd(rs2).
- `ex_reg_write`, `ex_mem_read`, `ex_mem_write` are 0 whenever `ex_valid` = 0.

## Timing
- Latency: one cycle from ID inputs to `ex_*` outputs. Forward muxes and `stall` are same-cycle combinational.
- Reset: all registered fields are 0, so `ex_valid`=0, `ex_a`=`ex_b`=`ex_store_data`=0, `ex_alu_control`=0000, `ex_rd`=0, all control outputs 0. `stall`=`ex_hold` (`lu`=0).
- Reset mid-operation clears EX immediately and asynchronously. It needs no clock edge.
- Load-use costs exactly one bubble:
  - Cycle N: `stall`=1.
  - Edge N+1: EX gets a bubble, and the load moves to MEM.
  - Cycle N+1: `lu`=0, and the dependent instruction loads next edge. It then takes the load data via MEM/WB forwarding.
- `flush` together with `lu`: bubble. `stall` is still 1 that cycle; upstream flush logic overrides it.
- `flush` together with `ex_hold`: flush wins, EX becomes a bubble.
- Hold does not mask forwarding. Forwarded values track the source inputs every cycle.

## Test plan
- Reset, then release with `id_valid`=0 -> `ex_valid`=0, all outputs 0, `stall`=0.
- ADD x3,x1,x2 (rs1_data=5, rs2_data=7, 0010) with no forwarding -> next cycle `ex_a`=5, `ex_b`=7, `ex_alu_control`=0010, `ex_rd`=3, `ex_reg_write`=1.
- EX's rs1=3 with `exmem_rd`=3 result 0x10 and `memwb_rd`=3 result 0x20 -> `ex_a`=0x10. Same test with rd=0 and rs1=0 -> `ex_a` = registered data, no forwarding.
- EX holds LW x5 and ID holds ADD x6,x5,x1 -> `stall`=1 for one cycle. Next cycle `ex_valid`=0. The cycle after, ADD is in EX with `memwb_rd`=5 result 0xAB, giving `ex_a`=0xAB.
- LW x5 in EX with ID ADDI x6,x4,1 (`id_rs2`=5, `id_rs2_used`=0) -> `stall`=0, no bubble.
- `ex_hold`=1 for 3 cycles -> `ex_*` frozen and `stall`=1. Assert `flush` with hold -> next cycle `ex_valid`=0. Async `rst` mid-hold -> outputs 0 without a clock edge.
